// File: rtl/banked_sync_ram_ctrl.sv
// banked_sync_ram_ctrl
// Banked single-port synchronous RAM with a valid/ready request/response interface.
// After reset, a sweep clears one row of every bank per cycle. Writes are posted and
// masked per lane. Reads return on a one-entry registered response stage with backpressure.
module banked_sync_ram_ctrl #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 16,
  parameter int NUM_BANKS  = 4,
  parameter int LANE_WIDTH = 8
) (
  input  logic                             clk_i,
  input  logic                             rst_ni,
  input  logic                             req_valid_i,
  output logic                             req_ready_o,
  input  logic                             req_we_i,
  input  logic [ADDR_WIDTH-1:0]            req_addr_i,
  input  logic [DATA_WIDTH-1:0]            req_wdata_i,
  input  logic [DATA_WIDTH/LANE_WIDTH-1:0] req_be_i,
  output logic                             rsp_valid_o,
  input  logic                             rsp_ready_i,
  output logic [DATA_WIDTH-1:0]            rsp_rdata_o,
  output logic                             init_done_o
);

  localparam int BANK_BITS  = $clog2(NUM_BANKS);
  localparam int ROW_BITS   = ADDR_WIDTH - BANK_BITS;
  localparam int BANK_DEPTH = 2 ** ROW_BITS;
  localparam int NUM_LANES  = DATA_WIDTH / LANE_WIDTH;

  // Reject parameter sets that cannot describe a valid banked memory.
  if (NUM_BANKS < 2 || (2 ** BANK_BITS) != NUM_BANKS) begin : g_bad_banks
    $error("NUM_BANKS must be a power of two and at least 2");
  end
  if (LANE_WIDTH < 1 || (DATA_WIDTH % LANE_WIDTH) != 0) begin : g_bad_lanes
    $error("DATA_WIDTH must be a whole multiple of LANE_WIDTH");
  end
  if (ADDR_WIDTH <= BANK_BITS) begin : g_bad_addr
    $error("ADDR_WIDTH must exceed the bank select width");
  end

  typedef enum logic [0:0] {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  state_e                state_q, state_d;
  logic [ROW_BITS-1:0]   init_cnt_q, init_cnt_d;
  logic                  init_done_q, init_done_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;

  logic [BANK_BITS-1:0]  bank_sel_s;
  logic [ROW_BITS-1:0]   row_s;
  logic                  accept_s;
  logic                  wr_acc_s;
  logic                  rd_acc_s;
  logic                  init_we_s;
  logic [DATA_WIDTH-1:0] rd_word_s;
  logic [DATA_WIDTH-1:0] bank_rdata_s [NUM_BANKS];

  assign bank_sel_s  = req_addr_i[ADDR_WIDTH-1 -: BANK_BITS];
  assign row_s       = req_addr_i[ROW_BITS-1:0];
  // The response slot is free when empty or being drained this very cycle.
  assign req_ready_o = (state_q == ST_RUN) && (!rsp_valid_q || rsp_ready_i);
  assign accept_s    = req_valid_i && req_ready_o;
  assign wr_acc_s    = accept_s && req_we_i && rst_ni;
  assign rd_acc_s    = accept_s && !req_we_i;
  assign init_we_s   = (state_q == ST_INIT) && rst_ni;

  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    logic [DATA_WIDTH-1:0] mem_q [BANK_DEPTH];
    logic                  wr_en_s;

    assign wr_en_s = wr_acc_s && (bank_sel_s == BANK_BITS'(b));

    // Bank storage: zero sweep during init, otherwise lane-masked request writes.
    always_ff @(posedge clk_i) begin
      if (init_we_s) begin
        mem_q[init_cnt_q] <= '0;
      end else if (wr_en_s) begin
        for (int l = 0; l < NUM_LANES; l++) begin
          if (req_be_i[l]) begin
            mem_q[row_s][l*LANE_WIDTH +: LANE_WIDTH] <= req_wdata_i[l*LANE_WIDTH +: LANE_WIDTH];
          end
        end
      end
    end

    assign bank_rdata_s[b] = mem_q[row_s];
  end

  // Select the addressed bank's word; only that bank feeds the response register.
  always_comb begin
    rd_word_s = '0;
    for (int b = 0; b < NUM_BANKS; b++) begin
      if (bank_sel_s == BANK_BITS'(b)) begin
        rd_word_s = bank_rdata_s[b];
      end else begin
        rd_word_s = rd_word_s;
      end
    end
  end

  // Control and response state registers with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q     <= ST_INIT;
      init_cnt_q  <= '0;
      init_done_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      init_cnt_q  <= init_cnt_d;
      init_done_q <= init_done_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  // Init sweep sequencing: advance one row per cycle, enter RUN after the last row.
  always_comb begin
    state_d     = state_q;
    init_cnt_d  = init_cnt_q;
    init_done_d = init_done_q;
    case (state_q)
      ST_INIT: begin
        init_cnt_d = init_cnt_q + ROW_BITS'(1);
        if (init_cnt_q == ROW_BITS'(BANK_DEPTH - 1)) begin
          state_d     = ST_RUN;
          init_done_d = 1'b1;
        end else begin
          state_d     = ST_INIT;
          init_done_d = 1'b0;
        end
      end
      ST_RUN: begin
        init_done_d = 1'b1;
      end
      default: begin
        state_d     = ST_INIT;
        init_cnt_d  = '0;
        init_done_d = 1'b0;
      end
    endcase
  end

  // Response stage: load on read accept, drain on consumer ready, otherwise hold.
  always_comb begin
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    if (rd_acc_s) begin
      rsp_valid_d = 1'b1;
      rsp_rdata_d = rd_word_s;
    end else if (rsp_ready_i) begin
      rsp_valid_d = 1'b0;
    end else begin
      rsp_valid_d = rsp_valid_q;
    end
  end

  assign rsp_valid_o = rsp_valid_q;
  assign rsp_rdata_o = rsp_rdata_q;
  assign init_done_o = init_done_q;

endmodule

// File: tb/tb_banked_sync_ram_ctrl.sv
// tb_banked_sync_ram_ctrl
// Directed bench for banked_sync_ram_ctrl with a 6-bit address (4 banks x 16 rows).
// Inputs change 1ns after the rising edge; outputs are sampled on the falling edge.
module tb_banked_sync_ram_ctrl;

  localparam int AW = 6;
  localparam int DW = 16;
  localparam int NB = 4;
  localparam int LW = 8;
  localparam int NL = DW / LW;

  // Bank-corner addresses: bank 0 row 0, bank 3 row 0, bank 1 row 0.
  localparam logic [AW-1:0] A_B0 = 6'h00;
  localparam logic [AW-1:0] A_B3 = 6'h30;
  localparam logic [AW-1:0] A_B1 = 6'h10;
  localparam logic [AW-1:0] A_BE = 6'h02;
  localparam logic [AW-1:0] A_RS = 6'h05;

  logic          clk_i = 1'b0;
  logic          rst_ni;
  logic          req_valid_i;
  logic          req_ready_o;
  logic          req_we_i;
  logic [AW-1:0] req_addr_i;
  logic [DW-1:0] req_wdata_i;
  logic [NL-1:0] req_be_i;
  logic          rsp_valid_o;
  logic          rsp_ready_i;
  logic [DW-1:0] rsp_rdata_o;
  logic          init_done_o;

  int total_q = 0;
  int bad_q   = 0;

  banked_sync_ram_ctrl #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .NUM_BANKS  (NB),
    .LANE_WIDTH (LW)
  ) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .req_valid_i (req_valid_i),
    .req_ready_o (req_ready_o),
    .req_we_i    (req_we_i),
    .req_addr_i  (req_addr_i),
    .req_wdata_i (req_wdata_i),
    .req_be_i    (req_be_i),
    .rsp_valid_o (rsp_valid_o),
    .rsp_ready_i (rsp_ready_i),
    .rsp_rdata_o (rsp_rdata_o),
    .init_done_o (init_done_o)
  );

  // Free-running 10ns clock.
  always #5 clk_i = ~clk_i;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total_q++;
    if (got !== exp) begin
      bad_q++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Present one request at posedge+1 and hold it until accepted (bounded).
  task automatic issue(input logic we, input logic [AW-1:0] addr,
                       input logic [DW-1:0] wdata, input logic [NL-1:0] be);
    logic acc;
    acc         = 1'b0;
    req_valid_i = 1'b1;
    req_we_i    = we;
    req_addr_i  = addr;
    req_wdata_i = wdata;
    req_be_i    = be;
    for (int n = 0; n < 50 && !acc; n++) begin
      @(negedge clk_i);
      acc = req_ready_o;
      @(posedge clk_i);
      #1;
    end
    req_valid_i = 1'b0;
    req_we_i    = 1'b0;
    if (!acc) check_val("accept_timeout", 32'd0, 32'd1);
  endtask

  // Read and check the response one cycle after the accepting edge.
  task automatic read_chk(input string tag, input logic [AW-1:0] addr, input logic [DW-1:0] exp);
    issue(1'b0, addr, '0, '0);
    @(negedge clk_i);
    check_val({tag, "_valid"}, {31'd0, rsp_valid_o}, 32'd1);
    check_val({tag, "_data"}, {16'd0, rsp_rdata_o}, {16'd0, exp});
    @(posedge clk_i);
    #1;
  endtask

  task automatic wait_init;
    int n;
    n = 0;
    while (!init_done_o && n < 100) begin
      @(posedge clk_i);
      #1;
      n++;
    end
    if (!init_done_o) check_val("init_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    rst_ni      = 1'b0;
    req_valid_i = 1'b0;
    req_we_i    = 1'b0;
    req_addr_i  = '0;
    req_wdata_i = '0;
    req_be_i    = '0;
    rsp_ready_i = 1'b1;

    // Test 1: reset for two edges, then a 16-cycle init sweep.
    @(posedge clk_i);
    @(posedge clk_i);
    #1;
    check_val("rst_rsp_valid", {31'd0, rsp_valid_o}, 32'd0);
    check_val("rst_rsp_rdata", {16'd0, rsp_rdata_o}, 32'd0);
    rst_ni = 1'b1;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk_i);
      check_val("init_done_low", {31'd0, init_done_o}, 32'd0);
      check_val("init_ready_low", {31'd0, req_ready_o}, 32'd0);
    end
    @(negedge clk_i);
    check_val("init_done_high", {31'd0, init_done_o}, 32'd1);
    check_val("run_ready_high", {31'd0, req_ready_o}, 32'd1);
    @(posedge clk_i);
    #1;

    // Test 2: writes to two banks, reads from those and an untouched bank.
    issue(1'b1, A_B0, 16'hBEEF, 2'b11);
    issue(1'b1, A_B3, 16'hCAFE, 2'b11);
    read_chk("rd_b0", A_B0, 16'hBEEF);
    read_chk("rd_b3", A_B3, 16'hCAFE);
    read_chk("rd_b1", A_B1, 16'h0000);

    // Test 3: lane masks, including an all-zero mask.
    issue(1'b1, A_BE, 16'h1234, 2'b11);
    issue(1'b1, A_BE, 16'hABCD, 2'b10);
    issue(1'b1, A_BE, 16'hFFFF, 2'b00);
    read_chk("rd_lanes", A_BE, 16'hAB34);
    @(negedge clk_i);
    check_val("drain_valid", {31'd0, rsp_valid_o}, 32'd0);
    check_val("drain_hold_data", {16'd0, rsp_rdata_o}, 32'h0000AB34);
    @(posedge clk_i);
    #1;

    // Test 4: backpressure holds the response, then release with a chained read.
    rsp_ready_i = 1'b0;
    issue(1'b0, A_B0, '0, '0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_i);
      check_val("bp_ready_low", {31'd0, req_ready_o}, 32'd0);
      check_val("bp_valid", {31'd0, rsp_valid_o}, 32'd1);
      check_val("bp_data", {16'd0, rsp_rdata_o}, 32'h0000BEEF);
      @(posedge clk_i);
      #1;
    end
    rsp_ready_i = 1'b1;
    read_chk("bp_chain", A_B3, 16'hCAFE);

    // Test 5: reset while a response is pending, then memory is re-zeroed.
    issue(1'b1, A_RS, 16'h5555, 2'b11);
    rsp_ready_i = 1'b0;
    issue(1'b0, A_RS, '0, '0);
    @(negedge clk_i);
    check_val("pre_rst_data", {16'd0, rsp_rdata_o}, 32'h00005555);
    rst_ni = 1'b0;
    @(negedge clk_i);
    check_val("mid_rst_valid", {31'd0, rsp_valid_o}, 32'd0);
    check_val("mid_rst_done", {31'd0, init_done_o}, 32'd0);
    @(posedge clk_i);
    #1;
    rst_ni      = 1'b1;
    rsp_ready_i = 1'b1;
    wait_init();
    read_chk("rezero_05", A_RS, 16'h0000);
    read_chk("rezero_00", A_B0, 16'h0000);

    // Test 6: fill rows 0..15 of bank 0, then stream 16 back-to-back reads.
    for (int i = 0; i < 16; i++) begin
      issue(1'b1, AW'(i), DW'(i * 3), 2'b11);
    end
    for (int i = 0; i < 16; i++) begin
      req_valid_i = 1'b1;
      req_we_i    = 1'b0;
      req_addr_i  = AW'(i);
      @(negedge clk_i);
      check_val("stream_ready", {31'd0, req_ready_o}, 32'd1);
      if (i > 0) begin
        check_val("stream_valid", {31'd0, rsp_valid_o}, 32'd1);
        check_val("stream_data", {16'd0, rsp_rdata_o}, 32'((i - 1) * 3));
      end
      @(posedge clk_i);
      #1;
    end
    req_valid_i = 1'b0;
    @(negedge clk_i);
    check_val("stream_last_valid", {31'd0, rsp_valid_o}, 32'd1);
    check_val("stream_last_data", {16'd0, rsp_rdata_o}, 32'd45);
    @(posedge clk_i);
    #1;
    @(negedge clk_i);
    check_val("stream_end_valid", {31'd0, rsp_valid_o}, 32'd0);

    $display("test done: total=%0d bad=%0d", total_q, bad_q);
    $finish;
  end

  // Absolute time limit so a stuck run still terminates.
  initial begin
    #200000;
    $display("FAIL global_timeout: got=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
